ripple_addsub_seq: RTL and testbench



---
 rtl/addsub_pkg.sv | 25 ++
 rtl/addsub_chunk.sv | 34 +++
 rtl/ripple_addsub_seq.sv | 164 ++++++++++++++++
 tb/tb_ripple_addsub_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential ripple adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the op input
//   state_t         : control FSM states (IDLE, CALC, DONE)
//   signed_limit()  : signed max (neg=0) or min (neg=1) bit pattern for a
//                     given width, returned in the low w bits of 64.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only the low w bits are meaningful; callers truncate to their width.
  // Valid for 2 <= w <= 64.
  function automatic logic [63:0] signed_limit(input int unsigned w, input logic neg);
    logic [63:0] msb_only;
    msb_only = 64'd1 << (w - 1);
    return neg ? msb_only : (msb_only - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
//   x, y      : CHUNK-bit addends
//   cin       : carry into bit 0
//   s         : CHUNK-bit sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (needed for signed overflow when this
//               slice holds the operand MSB)
module addsub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // c_chain[i] is the carry into bit i.
  logic [CHUNK:0] c_chain;

  assign c_chain[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign s[gi]           = x[gi] ^ y[gi] ^ c_chain[gi];
      assign c_chain[gi + 1] = (x[gi] & y[gi]) | (c_chain[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout     = c_chain[CHUNK];
  assign c_msb_in = c_chain[CHUNK-1];

endmodule

// File: rtl/ripple_addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit add or subtract
// is resolved CHUNK bits per clock through a registered carry, so the
// combinational carry path is only CHUNK bits long.
//
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, op             : operands; op 0 = a+b, 1 = a-b
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   sum, carry, overflow : result, raw MSB carry-out (subtract: 1 = no
//                          borrow), signed overflow
//
// Configuration macro ADDSUB_SATURATE_EN: when defined, an overflowing result
// is replaced by the signed limit in the direction of the true result; carry
// and overflow are reported unchanged. Otherwise sum wraps modulo 2^WIDTH.
//
// WIDTH must be >= 2 (and <= 64 when saturating); CHUNK must divide WIDTH.
module ripple_addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the index at least one bit wide so NCHUNK = 1 still elaborates.
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Slot arrays are padded to a power of two so any index value is in range.
  localparam int NSLOT  = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   idx_reg;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              cin_reg, carry_reg, ovf_reg;

  logic [CHUNK-1:0]  a_slot [NSLOT];
  logic [CHUNK-1:0]  b_slot [NSLOT];
  logic [CHUNK-1:0]  x_sel, y_sel, s_chunk;
  logic              cout_chunk, cmsb_chunk;
  logic              last_chunk, ovf_now;
  logic [WIDTH-1:0]  sum_next, sum_final;

  // ---------------------------------------------------------------- datapath
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NCHUNK) begin : g_used
        assign a_slot[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_slot[gi] = b_reg[gi*CHUNK +: CHUNK];
      end else begin : g_pad
        assign a_slot[gi] = '0;
        assign b_slot[gi] = '0;
      end
    end
  endgenerate

  assign x_sel = a_slot[idx_reg];
  assign y_sel = b_slot[idx_reg];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x        (x_sel),
    .y        (y_sel),
    .cin      (cin_reg),
    .s        (s_chunk),
    .cout     (cout_chunk),
    .c_msb_in (cmsb_chunk)
  );

  // Merge the freshly computed chunk into its slot of the sum register.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_merge
      assign sum_next[gi*CHUNK +: CHUNK] =
        (idx_reg == IDXW'(gi)) ? s_chunk : sum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign last_chunk = (idx_reg == LAST_IDX);
  // Only meaningful on the last chunk, where the slice holds the MSB.
  assign ovf_now    = cmsb_chunk ^ cout_chunk;

`ifdef ADDSUB_SATURATE_EN
  // The sign of a gives the direction of the true result: overflow only
  // happens when the result's sign disagrees with a's.
  assign sum_final = (last_chunk && ovf_now)
                     ? WIDTH'(signed_limit(WIDTH, a_reg[WIDTH-1]))
                     : sum_next;
`else
  assign sum_final = sum_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // Subtract as a + ~b + 1: invert b here, inject the +1 as carry-in.
            a_reg   <= a;
            b_reg   <= b ^ {WIDTH{op}};
            cin_reg <= (op == OP_SUB);
            idx_reg <= '0;
          end
        end
        CALC: begin
          sum_reg <= sum_final;
          cin_reg <= cout_chunk;
          if (last_chunk) begin
            carry_reg <= cout_chunk;
            ovf_reg   <= ovf_now;
          end else begin
            idx_reg <= idx_reg + IDXW'(1);
          end
        end
        default: ; // DONE holds all results stable
      endcase
    end
  end

  // ----------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  assign sum      = sum_reg;
  assign carry    = carry_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_ripple_addsub_seq.sv
// Scoreboard bench for ripple_addsub_seq: the driver pushes expected results
// from an arithmetic reference model, the monitor pops and compares whenever
// a result is handed over. A second 16/4 instance is checked directly.
module tb_ripple_addsub_seq;

  localparam int W  = 8;
  localparam int C  = 2;
  localparam int N  = W / C;
  localparam int W2 = 16;
  localparam int C2 = 4;
  localparam int N2 = W2 / C2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, op, out_valid, out_ready, carry, overflow;
  logic [W-1:0] a, b, sum;

  logic          in_valid2, in_ready2, op2, out_valid2, out_ready2, carry2, overflow2;
  logic [W2-1:0] a2, b2, sum2;

  ripple_addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  ripple_addsub_seq #(.WIDTH(W2), .CHUNK(C2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .carry(carry2), .overflow(overflow2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  bit   rand_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the true values.
  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                input logic opv, output logic [63:0] s,
                                output logic c, output logic v);
    longint unsigned mask, ua, ub;
    longint sa, sb, t, mx, mn;
    mask = (64'd1 << w) - 64'd1;
    ua = av & mask;
    ub = bv & mask;
    sa = (((ua >> (w - 1)) & 64'd1) == 64'd1) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = (((ub >> (w - 1)) & 64'd1) == 64'd1) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    if (opv == 1'b0) begin
      t = sa + sb;
      c = (((ua + ub) >> w) != 64'd0);
    end else begin
      t = sa - sb;
      c = (ua >= ub);
    end
    v = (t > mx) || (t < mn);
    s = 64'(t) & mask;
`ifdef ADDSUB_SATURATE_EN
    if (v) s = (t > mx) ? (64'(mx) & mask) : (64'(mn) & mask);
`endif
  endfunction

  // Issue one operation; operands are scrambled right after acceptance.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic opv, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 required 1");
      return;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    op = opv;
    @(posedge clk);
    #1;
    if (push) begin
      e.a = 64'(av);
      e.b = 64'(bv);
      e.op = opv;
      e.acc = cyc;
      model(W, e.a, e.b, opv, e.sum, e.carry, e.ovf);
      sbq.push_back(e);
    end
    in_valid = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 1'($urandom);
  endtask

  // Monitor: compare every handed-over result against the scoreboard.
  bit prev_valid = 0;
  int rise_cyc   = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
      end else begin
        if (out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum %0h required no output", sum);
          end else begin
            e = sbq.pop_front();
            $display("txn a=%0h b=%0h op=%0d -> sum=%0h carry=%0d ovf=%0d (exp %0h %0d %0d) lat=%0d",
                     e.a, e.b, e.op, sum, carry, overflow, e.sum, e.carry, e.ovf, rise_cyc - e.acc);
            chk("sum", 64'(sum), e.sum);
            chk("carry", 64'(carry), 64'(e.carry));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            chk("latency", 64'(rise_cyc - e.acc), 64'(N));
          end
        end
      end
    end
  end

  // Random backpressure, changed away from both edges' sampling points.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  logic [W-1:0] dir_a  [8] = '{8'h01, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'h80};
  logic [W-1:0] dir_b  [8] = '{8'h01, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h01};
  logic         dir_op [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [63:0] es;
    logic ec, ev;
    int n, acc;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; op2 = 1'b0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) send(dir_a[i], dir_b[i], dir_op[i], 1'b1);
    drain();

    // Backpressure: DONE held for 5 cycles, outputs stay put.
    @(posedge clk);
    #2 out_ready = 1'b0;
    send(8'h7F, 8'h7F, 1'b0, 1'b1);
    model(W, 64'h7F, 64'h7F, 1'b0, es, ec, ev);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_sum", 64'(sum), es);
      chk("stall_overflow", 64'(overflow), 64'(ev));
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    // Reset during the second CALC cycle aborts without a result.
    send(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid_after", 64'(out_valid), 64'd0);
    repeat (8) @(negedge clk);

    // Randomised traffic with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    drain();
    rand_rdy = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;

    // WIDTH=16, CHUNK=4 instance: directed first scenario plus random ones.
    for (int i = 0; i < 4; i++) begin
      logic [W2-1:0] va, vb;
      logic vo;
      va = (i == 0) ? 16'h0001 : W2'($urandom);
      vb = (i == 0) ? 16'h0001 : W2'($urandom);
      vo = (i == 0) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      n = 0;
      while (!in_ready2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      in_valid2 = 1'b1; a2 = va; b2 = vb; op2 = vo;
      @(posedge clk);
      #1 acc = cyc;
      in_valid2 = 1'b0; a2 = W2'($urandom); b2 = W2'($urandom); op2 = 1'($urandom);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid2 && n < 50);
      model(W2, 64'(va), 64'(vb), vo, es, ec, ev);
      $display("txn16 a=%0h b=%0h op=%0d -> sum=%0h carry=%0d ovf=%0d (exp %0h %0d %0d) lat=%0d",
               va, vb, vo, sum2, carry2, overflow2, es, ec, ev, cyc - acc);
      chk("w16_valid", 64'(out_valid2), 64'd1);
      chk("w16_latency", 64'(cyc - acc), 64'(N2));
      chk("w16_sum", 64'(sum2), es);
      chk("w16_carry", 64'(carry2), 64'(ec));
      chk("w16_overflow", 64'(overflow2), 64'(ev));
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
